chip8_mem_arbiter: RTL and testbench

- Parametrised, synthesizable CHIP-8 main memory with an N-port round-robin arbiter.
- Generalises the single-requester, one-cycle-read-latency memory behaviour the CPU already expects.
- Requesters include the CPU fetch/execute path, the display/sprite fetcher and the ROM loader.
- Sits between those requesters and a single-port RAM array (DEPTH = 2**ADDR_W bytes).

---
 rtl/chip8_mem_arbiter_pkg.sv | 22 ++
 rtl/chip8_mem_arbiter_if.sv | 28 ++
 rtl/chip8_mem_arbiter_rr_arbiter.sv | 43 ++++
 rtl/chip8_mem_arbiter.sv | 85 ++++++++
 tb/tb_chip8_mem_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/chip8_mem_arbiter_pkg.sv
// Shared CHIP-8 memory-system constants and the round-robin distance helper.
package chip8_pkg;

  localparam int unsigned CHIP8_ADDR_W    = 12;
  localparam int unsigned CHIP8_DATA_W    = 8;
  localparam int unsigned CHIP8_NUM_PORTS = 3;

  localparam logic [11:0] CHIP8_PROG_BASE = 12'h200;
  localparam logic [11:0] CHIP8_FONT_BASE = 12'h050;

  localparam int unsigned PORT_CPU    = 0;
  localparam int unsigned PORT_DISP   = 1;
  localparam int unsigned PORT_LOADER = 2;

  // Priority rank of a port relative to the last winner: 0 = highest priority.
  function automatic int unsigned rr_distance(input int unsigned port,
                                              input int unsigned last,
                                              input int unsigned n);
    return (port + n - last - 1) % n;
  endfunction

endpackage

// File: rtl/chip8_mem_arbiter_if.sv
// Requester-side bus of the CHIP-8 memory arbiter: flattened per-port request fields plus shared responses.
interface chip8_mem_arbiter_if #(
  parameter int unsigned NUM_PORTS = chip8_pkg::CHIP8_NUM_PORTS,
  parameter int unsigned ADDR_W    = chip8_pkg::CHIP8_ADDR_W,
  parameter int unsigned DATA_W    = chip8_pkg::CHIP8_DATA_W
);

  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;
  logic                        busy;
  logic                        wr_blocked;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata, busy, wr_blocked
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata, busy, wr_blocked
  );

endinterface

// File: rtl/chip8_mem_arbiter_rr_arbiter.sv
// Pure round-robin grant generator; the port after the last winner has highest priority.
module chip8_rr_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned NUM_PORTS = CHIP8_NUM_PORTS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] gnt
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] gnt_idx;
  int unsigned      best;

  // Two passes: find the best rank among requesters, then grant that single port.
  always_comb begin
    gnt     = '0;
    gnt_idx = last_grant;
    best    = NUM_PORTS;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (req[k] && (rr_distance(k, 32'(last_grant), NUM_PORTS) < best))
        best = rr_distance(k, 32'(last_grant), NUM_PORTS);
    end
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (reset && req[k] && (rr_distance(k, 32'(last_grant), NUM_PORTS) == best)) begin
        gnt[k]  = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      last_grant <= IDX_W'(NUM_PORTS - 1);
    else if (|gnt)
      last_grant <= gnt_idx;
  end

endmodule

// File: rtl/chip8_mem_arbiter.sv
// CHIP-8 main memory with N-port round-robin access and 1-cycle read latency.
// Optional write guard for the interpreter/font area: define CHIP8_MEM_WRITE_GUARD_EN.
module chip8_mem_arbiter
  import chip8_pkg::*;
#(
  parameter int unsigned        ADDR_W    = CHIP8_ADDR_W,
  parameter int unsigned        DATA_W    = CHIP8_DATA_W,
  parameter int unsigned        NUM_PORTS = CHIP8_NUM_PORTS,
  parameter logic [ADDR_W-1:0]  PROG_BASE = ADDR_W'(CHIP8_PROG_BASE)
) (
  input  logic                clk,
  input  logic                reset,
  chip8_mem_arbiter_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [NUM_PORTS-1:0] gnt;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic                 sel_we;
  logic                 any_gnt;
  logic                 blocked;
  logic                 wr_commit;
  logic                 rd_commit;

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [DATA_W-1:0]    rdata_q;

  chip8_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .gnt   (gnt)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      if (gnt[k]) begin
        sel_addr  = bus.addr[k*ADDR_W +: ADDR_W];
        sel_wdata = bus.wdata[k*DATA_W +: DATA_W];
        sel_we    = bus.we[k];
      end
    end
  end

  assign any_gnt = |gnt;

`ifdef CHIP8_MEM_WRITE_GUARD_EN
  // Only the loader (highest port) may write below the program area.
  assign blocked = any_gnt && sel_we && !gnt[NUM_PORTS-1] && (sel_addr < PROG_BASE);
`else
  assign blocked = 1'b0;
`endif

  assign wr_commit = any_gnt && sel_we && !blocked;
  assign rd_commit = any_gnt && !sel_we;

  // No reset on the array: contents survive reset, and gnt is already held low during reset.
  always_ff @(posedge clk) begin
    if (wr_commit)
      mem[sel_addr] <= sel_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rd_commit ? gnt : '0;
      rdata_q  <= rd_commit ? mem[sel_addr] : '0;
    end
  end

  assign bus.gnt        = gnt;
  assign bus.rvalid     = rvalid_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = |(bus.req & ~gnt);
  assign bus.wr_blocked = blocked;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Directed self-checking bench for chip8_mem_arbiter (3 ports, 4 KiB, 8-bit data).
module tb_chip8_mem_arbiter;

`ifdef CHIP8_MEM_WRITE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  chip8_mem_arbiter_if #(.NUM_PORTS(3), .ADDR_W(12), .DATA_W(8)) bus ();

  chip8_mem_arbiter #(
    .ADDR_W    (12),
    .DATA_W    (8),
    .NUM_PORTS (3),
    .PROG_BASE (12'h200)
  ) dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  task automatic drive(input int unsigned k, input logic r, input logic w,
                       input logic [11:0] a, input logic [7:0] d);
    bus.req[k]           = r;
    bus.we[k]            = w;
    bus.addr[k*12 +: 12] = a;
    bus.wdata[k*8 +: 8]  = d;
  endtask

  task automatic expect_cycle(input string tag, input logic [2:0] g, input logic [2:0] rv,
                              input logic [7:0] rd, input logic bsy, input logic wb);
    checks++;
    assert (bus.gnt === g) else begin
      failures++;
      $error("FAIL %s.gnt observed=%b expected=%b", tag, bus.gnt, g);
    end
    checks++;
    assert (bus.rvalid === rv) else begin
      failures++;
      $error("FAIL %s.rvalid observed=%b expected=%b", tag, bus.rvalid, rv);
    end
    if (rv != 3'b000) begin
      checks++;
      assert (bus.rdata === rd) else begin
        failures++;
        $error("FAIL %s.rdata observed=%h expected=%h", tag, bus.rdata, rd);
      end
    end
    checks++;
    assert (bus.busy === bsy) else begin
      failures++;
      $error("FAIL %s.busy observed=%b expected=%b", tag, bus.busy, bsy);
    end
    checks++;
    assert (bus.wr_blocked === wb) else begin
      failures++;
      $error("FAIL %s.wr_blocked observed=%b expected=%b", tag, bus.wr_blocked, wb);
    end
  endtask

  task automatic expect_rdata_zero(input string tag);
    checks++;
    assert (bus.rdata === 8'h00) else begin
      failures++;
      $error("FAIL %s.rdata observed=%h expected=00", tag, bus.rdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] rr_g  [6];
    logic [2:0] rr_rv [6];
    logic [7:0] rr_rd [6];
    rr_g  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rr_rv = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
    rr_rd = '{8'h00,  8'hA5,  8'h11,  8'h22,  8'hA5,  8'h11};

    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;

    // Reset state
    #1;
    expect_cycle("reset", 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);
    expect_rdata_zero("reset");
    @(negedge clk); reset_n = 1'b1;

    // Single port: write then back-to-back read
    @(negedge clk); drive(0, 1, 1, 12'h300, 8'hA5); #1;
    expect_cycle("sp_wr", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 1, 0, 12'h300, 8'h00); #1;
    expect_cycle("sp_rd", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h300, 8'h00); #1;
    expect_cycle("sp_rv", 3'b000, 3'b001, 8'hA5, 1'b0, 1'b0);
    @(negedge clk); #1;
    expect_cycle("sp_pulse", 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);

    // Preload ports 1 and 2 data
    @(negedge clk); drive(1, 1, 1, 12'h301, 8'h11); #1;
    expect_cycle("pre1", 3'b010, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(1, 0, 0, 12'h301, 8'h00); drive(2, 1, 1, 12'h302, 8'h22); #1;
    expect_cycle("pre2", 3'b100, 3'b000, 8'h00, 1'b0, 1'b0);

    // Contention: all three read continuously
    @(negedge clk);
    drive(0, 1, 0, 12'h300, 8'h00); drive(1, 1, 0, 12'h301, 8'h00); drive(2, 1, 0, 12'h302, 8'h00);
    #1;
    expect_cycle("rr0", rr_g[0], rr_rv[0], rr_rd[0], 1'b1, 1'b0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk); #1;
      expect_cycle($sformatf("rr%0d", i), rr_g[i], rr_rv[i], rr_rd[i], 1'b1, 1'b0);
    end
    @(negedge clk); bus.req = '0; #1;
    expect_cycle("rr_tail", 3'b000, 3'b100, 8'h22, 1'b0, 1'b0);

    // Fairness: port 0 streams, port 2 joins at cycle 5
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); drive(0, 1, 0, 12'h300, 8'h00); #1;
      expect_cycle($sformatf("fair%0d", c), 3'b001, (c == 0) ? 3'b000 : 3'b001, 8'hA5, 1'b0, 1'b0);
    end
    @(negedge clk); drive(2, 1, 0, 12'h302, 8'h00); #1;
    expect_cycle("fair5", 3'b100, 3'b001, 8'hA5, 1'b1, 1'b0);
    @(negedge clk); drive(2, 0, 0, 12'h302, 8'h00); #1;
    expect_cycle("fair6", 3'b001, 3'b100, 8'h22, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h300, 8'h00); #1;
    expect_cycle("fair7", 3'b000, 3'b001, 8'hA5, 1'b0, 1'b0);

    // Cancel: port 1 write loses to port 2, then withdraws
    @(negedge clk); drive(1, 1, 0, 12'h301, 8'h00); #1;
    expect_cycle("cx_rd1", 3'b010, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(1, 1, 1, 12'h301, 8'hEE); drive(2, 1, 0, 12'h302, 8'h00); #1;
    expect_cycle("cx_wait", 3'b100, 3'b010, 8'h11, 1'b1, 1'b0);
    @(negedge clk); drive(1, 0, 0, 12'h301, 8'h00); drive(2, 0, 0, 12'h302, 8'h00); #1;
    expect_cycle("cx_drop", 3'b000, 3'b100, 8'h22, 1'b0, 1'b0);
    @(negedge clk); drive(0, 1, 0, 12'h301, 8'h00); #1;
    expect_cycle("cx_chk", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h301, 8'h00); #1;
    expect_cycle("cx_ram", 3'b000, 3'b001, 8'h11, 1'b0, 1'b0);

    // Reset mid-operation, with a write pending during reset
    @(negedge clk); drive(0, 1, 0, 12'h300, 8'h00); #1;
    expect_cycle("rs_rd", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h300, 8'h00); drive(1, 1, 1, 12'h300, 8'h00); reset_n = 1'b0; #1;
    expect_cycle("rs_drop", 3'b000, 3'b000, 8'h00, 1'b1, 1'b0);
    expect_rdata_zero("rs_drop");
    @(negedge clk); #1;
    expect_cycle("rs_hold", 3'b000, 3'b000, 8'h00, 1'b1, 1'b0);
    expect_rdata_zero("rs_hold");
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 1, 0, 12'h300, 8'h00); drive(1, 1, 0, 12'h301, 8'h00); drive(2, 1, 0, 12'h302, 8'h00);
    #1;
    expect_cycle("rs_first", 3'b001, 3'b000, 8'h00, 1'b1, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h300, 8'h00); #1;
    expect_cycle("rs_keep", 3'b010, 3'b001, 8'hA5, 1'b1, 1'b0);
    @(negedge clk); drive(1, 0, 0, 12'h301, 8'h00); #1;
    expect_cycle("rs_p2", 3'b100, 3'b010, 8'h11, 1'b0, 1'b0);
    @(negedge clk); drive(2, 0, 0, 12'h302, 8'h00); #1;
    expect_cycle("rs_end", 3'b000, 3'b100, 8'h22, 1'b0, 1'b0);

    // Write guard on the font area
    @(negedge clk); drive(2, 1, 1, 12'h050, 8'h3C); #1;
    expect_cycle("g_load", 3'b100, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(2, 0, 0, 12'h050, 8'h00); drive(0, 1, 1, 12'h050, 8'hFF); #1;
    expect_cycle("g_cpu_wr", 3'b001, 3'b000, 8'h00, 1'b0, GUARD);
    @(negedge clk); drive(0, 1, 0, 12'h050, 8'h00); #1;
    expect_cycle("g_cpu_rd", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h050, 8'h00); #1;
    expect_cycle("g_cpu_rb", 3'b000, 3'b001, GUARD ? 8'h3C : 8'hFF, 1'b0, 1'b0);
    @(negedge clk); drive(2, 1, 1, 12'h050, 8'hFF); #1;
    expect_cycle("g_ld_wr", 3'b100, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(2, 0, 0, 12'h050, 8'h00); drive(0, 1, 0, 12'h050, 8'h00); #1;
    expect_cycle("g_ld_rd", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h050, 8'h00); #1;
    expect_cycle("g_ld_rb", 3'b000, 3'b001, 8'hFF, 1'b0, 1'b0);

    // Program-area boundary
    @(negedge clk); drive(0, 1, 1, 12'h200, 8'h5A); #1;
    expect_cycle("b_200_wr", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 1, 0, 12'h200, 8'h00); #1;
    expect_cycle("b_200_rd", 3'b001, 3'b000, 8'h00, 1'b0, 1'b0);
    @(negedge clk); drive(0, 0, 0, 12'h200, 8'h00); drive(1, 1, 1, 12'h1FF, 8'h77); #1;
    expect_cycle("b_1ff_wr", 3'b010, 3'b001, 8'h5A, 1'b0, GUARD);
    @(negedge clk); drive(1, 0, 0, 12'h1FF, 8'h00); #1;
    expect_cycle("b_idle", 3'b000, 3'b000, 8'h00, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
